// File: rtl/pwm_duty_core.sv
// pwm_duty_core: button-stepped saturating duty register driving a
// fixed-period PWM. The compare value is a shadow copy of the duty
// register, reloaded only when the counter wraps, so a period is never cut short.
module pwm_duty_core #(
   parameter int PERIOD    = 10,
   parameter int STEP      = 1,
   parameter int DUTY_INIT = 5,
   parameter int W         = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_q,
   input  logic         dec_q,
   output logic         pwm_out,
   output logic [W-1:0] duty,
   output logic         period_start
);

   localparam int            LAST_I = PERIOD - 1;
   localparam logic [W:0]    PER_X  = PERIOD[W:0];
   localparam logic [W:0]    STEP_X = STEP[W:0];
   localparam logic [W-1:0]  LAST   = LAST_I[W-1:0];
   localparam logic [W-1:0]  INIT   = DUTY_INIT[W-1:0];
   localparam logic          PWM_RST = (DUTY_INIT > 0);

   logic [W-1:0] cnt, cnt_next;
   logic [W-1:0] duty_reg, duty_next;
   logic [W-1:0] duty_act, act_next;
   logic         inc_prev, dec_prev;
   logic         inc_rise, dec_rise;
   logic [W:0]   sum;
   logic         pwm_next;

   // Rising-edge detect on the debounced levels.
   always_comb begin
      inc_rise = inc_q & ~inc_prev;
      dec_rise = dec_q & ~dec_prev;
   end

   // Saturating duty step; one extra bit so the sum cannot wrap, and the
   // difference is range-checked first so it never underflows.
   always_comb begin
      sum       = {1'b0, duty_reg} + STEP_X;
      duty_next = duty_reg;
      if (inc_rise && !dec_rise)
         duty_next = (sum > PER_X) ? PER_X[W-1:0] : sum[W-1:0];
      else if (dec_rise && !inc_rise)
         duty_next = ({1'b0, duty_reg} >= STEP_X) ? (duty_reg - STEP_X[W-1:0]) : '0;
   end

   // Next counter/shadow values; pwm is registered from these so that
   // pwm_out always equals (cnt < duty_act) in the same cycle.
   always_comb begin
      cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
      act_next = (cnt_next == '0) ? duty_next : duty_act;
      pwm_next = (cnt_next < act_next);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         inc_prev <= 1'b0;
         dec_prev <= 1'b0;
         duty_reg <= INIT;
         duty_act <= INIT;
         pwm_out  <= PWM_RST;
      end else begin
         cnt      <= cnt_next;
         inc_prev <= inc_q;
         dec_prev <= dec_q;
         duty_reg <= duty_next;
         duty_act <= act_next;
         pwm_out  <= pwm_next;
      end
   end

   assign duty         = duty_reg;
   assign period_start = (cnt == '0);

endmodule

// File: tb/tb_pwm_duty_core.sv
// Scoreboard bench for pwm_duty_core: a cycle model pushes the expected
// outputs when stimulus is driven; they are popped and compared after the edge.
module tb_pwm_duty_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inc_q = 1'b0;
   logic       dec_q = 1'b0;
   logic       pwm_out;
   logic [3:0] duty;
   logic       period_start;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int pwm;
      int ps;
      int duty;
   } exp_t;
   exp_t sbq[$];

   // reference model state (after the most recent posedge)
   int m_cnt = 0, m_duty = 5, m_act = 5;
   bit m_ip = 0, m_dp = 0;

   pwm_duty_core #(.PERIOD(10), .STEP(1), .DUTY_INIT(5), .W(4)) dut (
      .clk(clk), .rst_n(rst_n), .inc_q(inc_q), .dec_q(dec_q),
      .pwm_out(pwm_out), .duty(duty), .period_start(period_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // one clock: drive inputs, advance model, push expectation, then compare
   task automatic cycle(input bit i, input bit d, input bit r);
      exp_t e, o;
      bit ir, dr;
      @(negedge clk);
      inc_q = i; dec_q = d; rst_n = r;
      if (!r) begin
         m_cnt = 0; m_ip = 0; m_dp = 0; m_duty = 5; m_act = 5;
      end else begin
         ir = i && !m_ip;
         dr = d && !m_dp;
         m_ip = i; m_dp = d;
         if (ir && !dr)      m_duty = (m_duty + 1 > 10) ? 10 : m_duty + 1;
         else if (dr && !ir) m_duty = (m_duty < 1) ? 0 : m_duty - 1;
         m_cnt = (m_cnt + 1) % 10;
         if (m_cnt == 0) m_act = m_duty;
      end
      e.pwm  = (m_cnt < m_act) ? 1 : 0;
      e.ps   = (m_cnt == 0) ? 1 : 0;
      e.duty = m_duty;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      o = sbq.pop_front();
      chk("pwm_out", int'(pwm_out), o.pwm);
      chk("period_start", int'(period_start), o.ps);
      chk("duty", int'(duty), o.duty);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 1);
   endtask

   task automatic pulse(input bit i, input bit d);
      cycle(i, d, 1);
      cycle(0, 0, 1);
   endtask

   // idle until the model counter reaches c (bounded: at most one period)
   task automatic to_cnt(input int c);
      for (int k = 0; k < 10 && m_cnt != c; k++) cycle(0, 0, 1);
   endtask

   initial begin
      int hi;
      // reset state
      cycle(0, 0, 0);
      chk("rst_duty", int'(duty), 5);
      chk("rst_pwm", int'(pwm_out), 1);
      chk("rst_ps", int'(period_start), 1);

      // 5/5 waveform; also count highs over one full period
      hi = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(0, 0, 1);
         hi += int'(pwm_out);
      end
      chk("high_cnt_5", hi, 5);
      idle(20);

      // inc pulse at cnt=3: duty next cycle, pwm from next period
      to_cnt(2);
      cycle(1, 0, 1);
      chk("inc_duty6", int'(duty), 6);
      cycle(0, 0, 1);
      idle(25);

      // held inc gives exactly one step, then saturation at 10
      cycle(0, 0, 0);
      for (int k = 0; k < 20; k++) cycle(1, 0, 1);
      chk("hold_one_step", int'(duty), 6);
      cycle(0, 0, 1);
      for (int k = 0; k < 6; k++) pulse(1, 0);
      chk("sat_top", int'(duty), 10);
      idle(25);

      // down to 2, then three more decs: 1, 0, 0 (no wrap)
      for (int k = 0; k < 8; k++) pulse(0, 1);
      chk("duty2", int'(duty), 2);
      for (int k = 0; k < 3; k++) pulse(0, 1);
      chk("sat_bottom", int'(duty), 0);
      idle(25);

      // simultaneous rise: no change
      cycle(1, 1, 1);
      chk("both_rise", int'(duty), 0);
      cycle(0, 0, 1);
      // inc landing on the wrap edge takes effect in the new period
      to_cnt(9);
      cycle(1, 0, 1);
      chk("wrap_inc_duty", int'(duty), 1);
      chk("wrap_inc_pwm", int'(pwm_out), 1);
      cycle(0, 0, 1);
      idle(20);

      // duty 8, reset mid-period at cnt=6
      cycle(0, 0, 0);
      for (int k = 0; k < 3; k++) pulse(1, 0);
      idle(12);
      to_cnt(6);
      cycle(0, 0, 0);
      chk("midrst_duty", int'(duty), 5);
      chk("midrst_pwm", int'(pwm_out), 1);
      chk("midrst_ps", int'(period_start), 1);
      idle(25);

      // random slow-cadence stimulus with occasional reset
      for (int k = 0; k < 300; k++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 99) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
